// File: rtl/zone_luma_stat_if.sv
// Pixel-stream and zone-result bundle for zone_luma_stat.
// master: drives the pixel stream, vsync and mode, and receives zone values and status pulses.
// slave:  the statistics block, which consumes the stream and produces the results.
// Ports: data_de/data_gray (pixel stream), r_Vsync_0 (frame sync), led_mode (zone value select),
//        buf_flatted (8 bits per zone), o_frame_done / o_frame_err (one-cycle status pulses).
interface zone_luma_stat_if #(
    parameter int ZONES_X = 24,
    parameter int ZONES_Y = 15
);
    localparam int N = ZONES_X * ZONES_Y;

    logic             data_de;
    logic [7:0]       data_gray;
    logic             r_Vsync_0;
    logic [1:0]       led_mode;
    logic [8*N-1:0]   buf_flatted;
    logic             o_frame_done;
    logic             o_frame_err;

    modport master (
        output data_de, data_gray, r_Vsync_0, led_mode,
        input  buf_flatted, o_frame_done, o_frame_err
    );

    modport slave (
        input  data_de, data_gray, r_Vsync_0, led_mode,
        output buf_flatted, o_frame_done, o_frame_err
    );
endinterface

// File: rtl/zone_luma_stat.sv
// Per-zone luminance statistics (average / peak / mix / full-scale) with optional temporal IIR.
// Latency: buf_flatted and o_frame_done update one cycle after the registered active vsync edge.
// Backpressure: none; the pixel stream is consumed every cycle and never stalled.
// Ports: i_pix_clk, rst_n (async, active-low), bus (slave modport of zone_luma_stat_if).
module zone_luma_stat #(
    parameter int H_ACT        = 1280,
    parameter int V_ACT        = 800,
    parameter int ZONES_X      = 24,
    parameter int ZONES_Y      = 15,
    parameter int VS_POL       = 1,
    parameter int SMOOTH_SHIFT = 0
) (
    input  logic             i_pix_clk,
    input  logic             rst_n,
    zone_luma_stat_if.slave  bus
);
    localparam int ZW    = H_ACT / ZONES_X;
    localparam int ZH    = V_ACT / ZONES_Y;
    localparam int N     = ZONES_X * ZONES_Y;
    localparam int ZPIX  = ZW * ZH;
    localparam int SW    = 8 + $clog2(ZPIX);
    localparam int PW    = SW + 25;
    localparam int RECIP = ((1 << 24) + ZPIX / 2) / ZPIX;
    localparam int XW    = $clog2(H_ACT + 1) + 1;
    localparam int YW    = $clog2(V_ACT + 1) + 1;
    localparam int XIW   = $clog2(ZW);
    localparam int YIW   = $clog2(ZH);
    localparam int CXW   = $clog2(ZONES_X);
    localparam int CYW   = $clog2(ZONES_Y);
    localparam int CXW1  = CXW + 1;
    localparam int CYW1  = CYW + 1;
    localparam int ZNW   = $clog2(N);

    localparam logic            VS_ACT  = (VS_POL != 0);
    localparam logic [XW-1:0]   X_FULL  = XW'(H_ACT);
    localparam logic [YW-1:0]   Y_FULL  = YW'(V_ACT);
    localparam logic [XIW-1:0]  XI_LAST = XIW'(ZW - 1);
    localparam logic [YIW-1:0]  YI_LAST = YIW'(ZH - 1);
    localparam logic [CXW:0]    ZX_LIM  = CXW1'(ZONES_X);
    localparam logic [CYW:0]    ZY_LIM  = CYW1'(ZONES_Y);
    localparam logic [CXW-1:0]  CX_LAST = CXW'(ZONES_X - 1);
    localparam logic [PW-1:0]   RECIP_W = PW'(RECIP);
    localparam logic [PW-1:0]   HALF    = PW'(1 << 23);

    typedef enum logic [1:0] {IDLE, ACC, WB, COMMIT} state_t;

    // registered inputs
    logic            vs_q, vs_q2, de_q, de_q2;
    logic [7:0]      gray_q;

    // raster position
    logic [XW-1:0]   x_cnt;
    logic [YW-1:0]   y_cnt;
    logic [XIW-1:0]  xin_cnt;
    logic [YIW-1:0]  yin_cnt;
    logic [CXW:0]    zx_cnt;   // saturates at ZONES_X: pixels past the zone grid
    logic [CYW:0]    zy_cnt;   // saturates at ZONES_Y: lines past the zone grid

    state_t          state;
    logic [1:0]      mode_q;
    logic            bad_q, commit_bad, done_q, err_q;
    logic [CXW-1:0]  wb_idx;
    logic [ZNW-1:0]  wb_zone;  // zone rows are written back in order, so a running index suffices
    logic [SW-1:0]   col_sum [ZONES_X];
    logic [7:0]      col_max [ZONES_X];
    logic [7:0]      work_buf [N];
    logic [8*N-1:0]  buf_q;

    logic vs_edge, de_rise, de_fall, line_bad, row_end, pix_in;

    assign vs_edge  = (vs_q == VS_ACT) && (vs_q2 != VS_ACT);
    assign de_rise  = de_q & ~de_q2;
    assign de_fall  = ~de_q & de_q2;
    assign line_bad = de_fall && (x_cnt != X_FULL);
    assign row_end  = de_fall && (zy_cnt != ZY_LIM) && (yin_cnt == YI_LAST);
    assign pix_in   = de_q && (zx_cnt != ZX_LIM) && (zy_cnt != ZY_LIM);

    assign bus.buf_flatted  = buf_q;
    assign bus.o_frame_done = done_q;
    assign bus.o_frame_err  = err_q;

    always_ff @(posedge i_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q    <= ~VS_ACT;
            vs_q2   <= ~VS_ACT;
            de_q    <= 1'b0;
            de_q2   <= 1'b0;
            gray_q  <= '0;
            x_cnt   <= '0;
            y_cnt   <= '0;
            xin_cnt <= '0;
            yin_cnt <= '0;
            zx_cnt  <= '0;
            zy_cnt  <= '0;
        end else begin
            vs_q   <= bus.r_Vsync_0;
            vs_q2  <= vs_q;
            de_q   <= bus.data_de;
            de_q2  <= de_q;
            gray_q <= bus.data_gray;

            if (de_fall) begin
                x_cnt   <= '0;
                xin_cnt <= '0;
                zx_cnt  <= '0;
            end else if (de_q) begin
                if (x_cnt != '1) x_cnt <= x_cnt + 1'b1;
                if (zx_cnt != ZX_LIM) begin
                    if (xin_cnt == XI_LAST) begin
                        xin_cnt <= '0;
                        zx_cnt  <= zx_cnt + 1'b1;
                    end else begin
                        xin_cnt <= xin_cnt + 1'b1;
                    end
                end
            end

            if (vs_edge) begin
                y_cnt   <= '0;
                yin_cnt <= '0;
                zy_cnt  <= '0;
            end else if (de_fall) begin
                if (y_cnt != '1) y_cnt <= y_cnt + 1'b1;
                if (zy_cnt != ZY_LIM) begin
                    if (yin_cnt == YI_LAST) begin
                        yin_cnt <= '0;
                        zy_cnt  <= zy_cnt + 1'b1;
                    end else begin
                        yin_cnt <= yin_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // zone value for the column being written back
    logic [SW-1:0] wb_sum;
    logic [7:0]    wb_peak, wb_avg, wb_val;
    logic [PW-1:0] wb_prod;
    logic [8:0]    wb_mix;

    always_comb begin
        wb_sum  = col_sum[wb_idx];
        wb_peak = col_max[wb_idx];
        wb_prod = PW'(wb_sum) * RECIP_W + HALF;
        wb_avg  = wb_prod[24 +: 8];
        wb_mix  = {1'b0, wb_avg} + {1'b0, wb_peak} + 9'd1;
        case (mode_q)
            2'b00:   wb_val = wb_avg;
            2'b01:   wb_val = wb_peak;
            2'b10:   wb_val = wb_mix[8:1];
            default: wb_val = 8'hFF;
        endcase
    end

    // committed value per zone; the IIR step always lands between prev and work, so 8 bits suffice
    logic [8*N-1:0]    commit_val;
    logic signed [8:0] sm_diff, sm_res;

    always_comb begin
        commit_val = '0;
        sm_diff    = '0;
        sm_res     = '0;
        for (int z = 0; z < N; z++) begin
            sm_diff = $signed({1'b0, work_buf[z]}) - $signed({1'b0, buf_q[8*z +: 8]});
            sm_res  = $signed({1'b0, buf_q[8*z +: 8]}) + (sm_diff >>> SMOOTH_SHIFT);
            commit_val[8*z +: 8] = (SMOOTH_SHIFT == 0) ? work_buf[z] : sm_res[7:0];
        end
    end

    always_ff @(posedge i_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode_q     <= '0;
            bad_q      <= 1'b0;
            commit_bad <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wb_idx     <= '0;
            wb_zone    <= '0;
            buf_q      <= '0;
            for (int c = 0; c < ZONES_X; c++) begin
                col_sum[c] <= '0;
                col_max[c] <= '0;
            end
            for (int z = 0; z < N; z++) work_buf[z] <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            if (state != IDLE && (line_bad || (state == WB && de_rise))) bad_q <= 1'b1;

            // every active vsync edge starts a fresh frame, overriding the flag set above
            if (vs_edge) begin
                bad_q   <= 1'b0;
                mode_q  <= bus.led_mode;
                wb_zone <= '0;
                for (int c = 0; c < ZONES_X; c++) begin
                    col_sum[c] <= '0;
                    col_max[c] <= '0;
                end
            end

            case (state)
                IDLE: begin
                    if (vs_edge) state <= ACC;
                end
                ACC: begin
                    if (vs_edge) begin
                        commit_bad <= bad_q | line_bad | (y_cnt != Y_FULL);
                        state      <= COMMIT;
                    end else begin
                        if (pix_in) begin
                            col_sum[zx_cnt[CXW-1:0]] <= col_sum[zx_cnt[CXW-1:0]]
                                                        + {{(SW-8){1'b0}}, gray_q};
                            if (gray_q > col_max[zx_cnt[CXW-1:0]])
                                col_max[zx_cnt[CXW-1:0]] <= gray_q;
                        end
                        if (row_end) begin
                            wb_idx <= '0;
                            state  <= WB;
                        end
                    end
                end
                WB: begin
                    if (vs_edge) begin
                        commit_bad <= 1'b1;
                        state      <= COMMIT;
                    end else begin
                        work_buf[wb_zone] <= wb_val;
                        col_sum[wb_idx]   <= '0;
                        col_max[wb_idx]   <= '0;
                        wb_zone           <= wb_zone + 1'b1;
                        if (wb_idx == CX_LAST) state <= ACC;
                        else                   wb_idx <= wb_idx + 1'b1;
                    end
                end
                COMMIT: begin
                    if (commit_bad) begin
                        err_q <= 1'b1;
                    end else begin
                        buf_q  <= commit_val;
                        done_q <= 1'b1;
                    end
                    state <= ACC;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_zone_luma_stat.sv
// Bench for zone_luma_stat: 8x4 frame, 2x2 zones of 4x2 pixels, 6-cycle line blanking.
// A second instance with SMOOTH_SHIFT=1 sees the same stream for the IIR sequence.
module tb_zone_luma_stat;
    localparam int H = 8, V = 4, ZX = 2, ZY = 2, BLANK = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       de = 1'b0, vs = 1'b0;
    logic [7:0] gray = 8'd0;
    logic [1:0] mode = 2'b00;

    always #5 clk = ~clk;

    zone_luma_stat_if #(.ZONES_X(ZX), .ZONES_Y(ZY)) bus0 ();
    zone_luma_stat_if #(.ZONES_X(ZX), .ZONES_Y(ZY)) bus1 ();

    assign bus0.data_de = de;   assign bus1.data_de = de;
    assign bus0.data_gray = gray; assign bus1.data_gray = gray;
    assign bus0.r_Vsync_0 = vs; assign bus1.r_Vsync_0 = vs;
    assign bus0.led_mode = mode; assign bus1.led_mode = mode;

    zone_luma_stat #(.H_ACT(H), .V_ACT(V), .ZONES_X(ZX), .ZONES_Y(ZY),
                     .VS_POL(1), .SMOOTH_SHIFT(0))
        dut (.i_pix_clk(clk), .rst_n(rst_n), .bus(bus0));

    zone_luma_stat #(.H_ACT(H), .V_ACT(V), .ZONES_X(ZX), .ZONES_Y(ZY),
                     .VS_POL(1), .SMOOTH_SHIFT(1))
        dut_s (.i_pix_clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_cmp = 0, n_bad = 0;
    int done_cnt = 0, err_cnt = 0;

    always @(negedge clk) begin
        if (bus0.o_frame_done) done_cnt++;
        if (bus0.o_frame_err)  err_cnt++;
    end

    logic [7:0] img [V][H];

    typedef struct {
        int         fill;
        int         grad;     // 1: pixel = x*16 + y*4
        int         sx, sy, sv;
        logic [1:0] md;
        int         mid_en;   // change led_mode after line 1
        logic [1:0] mid_md;
        int         short_y;  // line carrying H-1 pixels, -1 for none
        int         e_done, e_err;
        logic [31:0] e_buf;   // {zone3, zone2, zone1, zone0}
    } vec_t;

    localparam int NV = 7;
    vec_t vt [NV];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic build(input int fill, input int grad, input int sx, input int sy, input int sv);
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                img[y][x] = grad ? 8'(x*16 + y*4) : 8'(fill);
        if (sx >= 0) img[sy][sx] = 8'(sv);
    endtask

    task automatic send_line(input int y, input int len, input int blank);
        for (int x = 0; x < len; x++) begin
            de = 1'b1;
            gray = img[y][x];
            cyc(1);
        end
        de = 1'b0;
        gray = 8'd0;
        cyc(blank);
    endtask

    task automatic send_frame(input int short_y, input int blank_row0, input int blank_last,
                              input int mid_en, input logic [1:0] mid_md);
        for (int y = 0; y < V; y++) begin
            send_line(y, (y == short_y) ? H - 1 : H,
                      (y == V - 1) ? blank_last : ((y == 1) ? blank_row0 : BLANK));
            if (mid_en != 0 && y == 1) mode = mid_md;
        end
    endtask

    task automatic vsync_and_check(input string tag, input int ed, input int ee, input logic [31:0] eb);
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        vs = 1'b1;
        cyc(2);
        vs = 1'b0;
        cyc(8);
        check({tag, " done pulses"}, 32'(done_cnt - d0), 32'(ed));
        check({tag, " err pulses"}, 32'(err_cnt - e0), 32'(ee));
        for (int z = 0; z < 4; z++)
            check($sformatf("%s zone%0d", tag, z), {24'd0, bus0.buf_flatted[8*z +: 8]},
                  {24'd0, eb[8*z +: 8]});
    endtask

    logic [7:0] sm_exp [3];

    initial begin
        //         fill grad sx sy sv  md    mid mid_md short done err  expected zones {z3,z2,z1,z0}
        vt[0] = '{100, 0, -1, 0, 0,   2'b00, 0, 2'b00, -1, 1, 0, {8'd100, 8'd100, 8'd100, 8'd100}};
        vt[1] = '{10,  0,  5, 3, 250, 2'b01, 0, 2'b00, -1, 1, 0, {8'd250, 8'd10, 8'd10, 8'd10}};
        // zone (1,1): avg = (7*10+250)/8 = 40, peak 250 -> (40+250+1)>>1 = 145
        vt[2] = '{10,  0,  5, 3, 250, 2'b10, 0, 2'b00, -1, 1, 0, {8'd145, 8'd10, 8'd10, 8'd10}};
        vt[3] = '{50,  0, -1, 0, 0,   2'b00, 0, 2'b00,  2, 0, 1, {8'd145, 8'd10, 8'd10, 8'd10}};
        vt[4] = '{77,  0, -1, 0, 0,   2'b11, 1, 2'b00, -1, 1, 0, 32'hFFFF_FFFF};
        // gradient averages: (0,0)=26 (1,0)=90 (0,1)=34 (1,1)=98
        vt[5] = '{0,   1, -1, 0, 0,   2'b00, 0, 2'b00, -1, 1, 0, {8'd98, 8'd34, 8'd90, 8'd26}};
        // 4/8 = 0.5 rounds up to 1
        vt[6] = '{0,   0,  0, 0, 4,   2'b00, 0, 2'b00, -1, 1, 0, {8'd0, 8'd0, 8'd0, 8'd1}};
        sm_exp[0] = 8'd100;
        sm_exp[1] = 8'd150;
        sm_exp[2] = 8'd175;

        rst_n = 1'b0;
        cyc(3);
        check("reset buf", bus0.buf_flatted, 32'h0);
        check("reset done", {31'd0, bus0.o_frame_done}, 32'h0);
        check("reset err", {31'd0, bus0.o_frame_err}, 32'h0);
        rst_n = 1'b1;
        cyc(3);

        mode = vt[0].md;
        vsync_and_check("first vsync", 0, 0, 32'h0);

        for (int i = 0; i < NV; i++) begin
            build(vt[i].fill, vt[i].grad, vt[i].sx, vt[i].sy, vt[i].sv);
            send_frame(vt[i].short_y, BLANK, BLANK, vt[i].mid_en, vt[i].mid_md);
            mode = (i < NV - 1) ? vt[i + 1].md : 2'b00;
            vsync_and_check($sformatf("vec%0d", i), vt[i].e_done, vt[i].e_err, vt[i].e_buf);
        end

        // vsync one cycle after the last line ends lands inside writeback
        build(100, 0, -1, 0, 0);
        send_frame(-1, BLANK, 1, 0, 2'b00);
        vsync_and_check("wb abort", 0, 1, vt[NV - 1].e_buf);

        // next line starts one cycle after zone row 0 ends, during writeback
        send_frame(-1, 1, BLANK, 0, 2'b00);
        vsync_and_check("de in wb", 0, 1, vt[NV - 1].e_buf);

        build(60, 0, -1, 0, 0);
        send_frame(-1, BLANK, BLANK, 0, 2'b00);
        vsync_and_check("recover", 1, 0, 32'h3C3C_3C3C);

        // reset mid-frame, then the first vsync only restarts framing
        build(200, 0, -1, 0, 0);
        send_line(0, H, BLANK);
        send_line(1, H, BLANK);
        rst_n = 1'b0;
        #1;
        check("midrst buf", bus0.buf_flatted, 32'h0);
        check("midrst buf smooth", bus1.buf_flatted, 32'h0);
        check("midrst done", {31'd0, bus0.o_frame_done}, 32'h0);
        cyc(2);
        rst_n = 1'b1;
        send_line(2, H, BLANK);
        send_line(3, H, BLANK);
        vsync_and_check("post reset vsync", 0, 0, 32'h0);

        for (int k = 0; k < 3; k++) begin
            send_frame(-1, BLANK, BLANK, 0, 2'b00);
            vsync_and_check($sformatf("gray200 f%0d", k), 1, 0, 32'hC8C8_C8C8);
            for (int z = 0; z < 4; z++)
                check($sformatf("smooth f%0d zone%0d", k, z), {24'd0, bus1.buf_flatted[8*z +: 8]},
                      {24'd0, sm_exp[k]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
